// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush-driven bubbles
// and a saturating count of hazard bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [3:0]        id_ALUOp,
  input  logic              id_ALUSrc,
  input  logic              id_RegDst,
  input  logic              id_MemWrite,
  input  logic              id_MemRead,
  input  logic              id_RegWrite,
  input  logic              id_MemtoReg,
  input  logic              id_Branch,
  input  logic              id_Beq,
  input  logic              id_Jump,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  output logic              stall,
  output logic              ex_valid,
  output logic [3:0]        ex_ALUOp,
  output logic              ex_ALUSrc,
  output logic              ex_RegDst,
  output logic              ex_MemWrite,
  output logic              ex_MemRead,
  output logic              ex_RegWrite,
  output logic              ex_MemtoReg,
  output logic              ex_Branch,
  output logic              ex_Beq,
  output logic              ex_Jump,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [3:0]       ALUOP_LUI = 4'b0111;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic              r_vld_p1;
  logic [3:0]        r_aluop_p1;
  logic              r_alusrc_p1, r_regdst_p1, r_memwrite_p1, r_memread_p1;
  logic              r_regwrite_p1, r_memtoreg_p1, r_branch_p1, r_beq_p1, r_jump_p1;
  logic [DATA_W-1:0] r_pc4_p1, r_rs_data_p1, r_rt_data_p1, r_imm_p1;
  logic [4:0]        r_rs_p1, r_rt_p1, r_rd_p1;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_uses_rs, w_uses_rt, w_hazard, w_bubble;

  // ID stage: which source registers the instruction actually reads
  assign w_uses_rs = ~id_Jump & (id_ALUOp != ALUOP_LUI);
  assign w_uses_rt = ~id_Jump & (~id_ALUSrc | id_MemWrite);

  assign w_hazard = r_vld_p1 & r_memread_p1 & (r_rt_p1 != 5'd0) & id_valid &
                    ((w_uses_rs & (r_rt_p1 == id_rs)) | (w_uses_rt & (r_rt_p1 == id_rt)));
  assign w_bubble = flush | w_hazard;
  assign stall    = w_hazard & ~flush;

  // ID -> EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_bubble) begin
      r_vld_p1      <= 1'b0;
      r_aluop_p1    <= '0;
      r_alusrc_p1   <= 1'b0;
      r_regdst_p1   <= 1'b0;
      r_memwrite_p1 <= 1'b0;
      r_memread_p1  <= 1'b0;
      r_regwrite_p1 <= 1'b0;
      r_memtoreg_p1 <= 1'b0;
      r_branch_p1   <= 1'b0;
      r_beq_p1      <= 1'b0;
      r_jump_p1     <= 1'b0;
      r_pc4_p1      <= '0;
      r_rs_data_p1  <= '0;
      r_rt_data_p1  <= '0;
      r_imm_p1      <= '0;
      r_rs_p1       <= '0;
      r_rt_p1       <= '0;
      r_rd_p1       <= '0;
    end else begin
      r_vld_p1      <= id_valid;
      r_aluop_p1    <= id_valid ? id_ALUOp : 4'd0;
      r_alusrc_p1   <= id_valid & id_ALUSrc;
      r_regdst_p1   <= id_valid & id_RegDst;
      r_memwrite_p1 <= id_valid & id_MemWrite;
      r_memread_p1  <= id_valid & id_MemRead;
      r_regwrite_p1 <= id_valid & id_RegWrite;
      r_memtoreg_p1 <= id_valid & id_MemtoReg;
      r_branch_p1   <= id_valid & id_Branch;
      // Decoder leaves Beq undefined outside branch opcodes
      r_beq_p1      <= id_valid & id_Branch & id_Beq;
      r_jump_p1     <= id_valid & id_Jump;
      r_pc4_p1      <= id_pc4;
      r_rs_data_p1  <= id_rs_data;
      r_rt_data_p1  <= id_rt_data;
      r_imm_p1      <= id_imm;
      r_rs_p1       <= id_rs;
      r_rt_p1       <= id_rt;
      r_rd_p1       <= id_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (stall) begin
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  assign ex_valid    = r_vld_p1;
  assign ex_ALUOp    = r_aluop_p1;
  assign ex_ALUSrc   = r_alusrc_p1;
  assign ex_RegDst   = r_regdst_p1;
  assign ex_MemWrite = r_memwrite_p1;
  assign ex_MemRead  = r_memread_p1;
  assign ex_RegWrite = r_regwrite_p1;
  assign ex_MemtoReg = r_memtoreg_p1;
  assign ex_Branch   = r_branch_p1;
  assign ex_Beq      = r_beq_p1;
  assign ex_Jump     = r_jump_p1;
  assign ex_pc4      = r_pc4_p1;
  assign ex_rs_data  = r_rs_data_p1;
  assign ex_rt_data  = r_rt_data_p1;
  assign ex_imm      = r_imm_p1;
  assign ex_rs       = r_rs_p1;
  assign ex_rt       = r_rt_p1;
  assign ex_rd       = r_rd_p1;
  assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage placed directly downstream of the main control decoder.
- Registers the decoder's control bundle together with the ID-stage operands, so the EX stage sees a stable set of signals for one cycle.
- Contains load-use hazard detection: on a hazard it inserts a bubble into EX and stalls the PC and IF/ID.
- Supports a flush from branch/jump resolution, and keeps a saturating count of hazard bubbles for performance reporting.

Parameters:
- DATA_W, 32, width of operand, immediate and PC+4 paths.
- CNT_W, 16, width of the hazard-bubble counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  kill the instruction entering EX (branch taken / jump)
- id_valid  in  1  ID stage holds a real instruction
- id_ALUOp  in  4  decoder ALUOp
- id_ALUSrc, id_RegDst, id_MemWrite, id_MemRead, id_RegWrite, id_MemtoReg, id_Branch, id_Beq, id_Jump  in  1 each  decoder controls
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign/zero-extended immediate
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_ALUOp  out  4; ex_ALUSrc, ex_RegDst, ex_MemWrite, ex_MemRead, ex_RegWrite, ex_MemtoReg, ex_Branch, ex_Beq, ex_Jump  out  1 each  registered controls
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered data
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers
- bubble_cnt  out  CNT_W  saturating count of hazard bubbles

Behaviour:
- Reset (asynchronous, active-high): every registered output is 0, including ex_valid and bubble_cnt. stall is therefore 0.
- Register-use terms (combinational, from ID controls):
  - uses_rs = ~id_Jump & (id_ALUOp != 4'b0111). lui does not read rs.
  - uses_rt = ~id_Jump & (~id_ALUSrc | id_MemWrite). Covers R-type, beq/bne and sw.
- Hazard (combinational) = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((uses_rs & ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
- stall = hazard & ~flush. Flush masks stall so the fetch redirect proceeds.
- Priority at each rising clk edge: flush > hazard > normal load.
  - flush = 1: load a bubble. All ex_ controls 0, ex_valid 0, all ex_ data and specifiers 0. bubble_cnt unchanged.
  - hazard = 1 and flush = 0: load the same bubble. bubble_cnt increments by 1, saturating at all-ones (no wrap).
  - Otherwise: load all id_ inputs, with two adjustments:
    - ex_valid = id_valid.
    - ex_Beq = id_Beq & id_Branch, because the decoder leaves Beq unspecified for non-branch opcodes.
  - When id_valid = 0, all control outputs load as 0 regardless of the id_ control inputs (a bubble from upstream).
- Latency: 1 cycle from ID to EX. A load-use hazard costs exactly one bubble: the next cycle ex_MemRead = 0, so stall deasserts and the held ID instruction advances.
- Back-to-back loads: each dependent load produces its own single bubble. There are no multi-cycle stalls.
- Register 0 never causes a hazard.
- rst asserted mid-operation clears state immediately, without waiting for a clock edge. Behaviour after rst release is as from power-up.

Test Plan:
- Reset: assert rst asynchronously between clock edges with all inputs non-zero -> ex_valid = 0, ex_ALUOp = 0, bubble_cnt = 0 and stall = 0 immediately, with no clock edge required.
- Pass-through: R-type (ALUOp = 4'b1000, RegDst = 1, RegWrite = 1), rs = 3, rt = 4, rd = 5, rs_data = 32'h11, rt_data = 32'h22 -> one cycle later all ex_ fields equal these values, ex_valid = 1, ex_Beq = 0.
- Load-use: lw with rt = 8, followed by add with rs = 8 -> stall = 1 for exactly one cycle, an EX bubble appears (ex_RegWrite = 0), bubble_cnt = 1, then the add enters EX.
  - Repeat with lw rt = 0 -> no stall.
  - Repeat with lui whose rs field = 8 -> no stall.
- Flush vs hazard: hazard and flush asserted in the same cycle -> stall = 0, a bubble is loaded, bubble_cnt is unchanged.
- Beq masking: id_Branch = 0 with id_Beq = 1 -> ex_Beq = 0. id_Branch = 1, id_Beq = 1 -> ex_Beq = 1.
- Saturation: with CNT_W = 4, force 20 hazards -> bubble_cnt holds at 4'hF.
